// File: rtl/fifo_sync_if.sv
// fifo_sync_if: producer/consumer handshake bundle for fifo_sync
// Carries almost_full/almost_empty only when FIFO_ALMOST_FLAGS_EN is defined
interface fifo_sync_if #(
    parameter int PTR_WIDTH = 8,
    parameter int DATA_WIDTH = 1
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_wr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_rd;
    logic                  full;
    logic                  empty;
    logic [PTR_WIDTH:0]    count;
    logic                  oflow;
    logic                  uflow;
`ifdef FIFO_ALMOST_FLAGS_EN
    logic                  almost_full;
    logic                  almost_empty;
`endif

    modport master (
        output wr_en, data_wr, rd_en,
        input  data_rd, full, empty, count, oflow, uflow
`ifdef FIFO_ALMOST_FLAGS_EN
        , input almost_full, almost_empty
`endif
    );

    modport slave (
        input  wr_en, data_wr, rd_en,
        output data_rd, full, empty, count, oflow, uflow
`ifdef FIFO_ALMOST_FLAGS_EN
        , output almost_full, almost_empty
`endif
    );
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with registered status, occupancy and overflow/underflow pulses
// Define FIFO_ALMOST_FLAGS_EN to add almost_full/almost_empty (thresholds AF_LEVEL/AE_LEVEL)
module fifo_sync #(
    parameter int PTR_WIDTH = 8,
    parameter int DATA_WIDTH = 1
`ifdef FIFO_ALMOST_FLAGS_EN
    , parameter int AF_LEVEL = 2**PTR_WIDTH-4,
    parameter int AE_LEVEL = 4
`endif
) (
    input  logic       aclk,
    input  logic       areset,
    fifo_sync_if.slave bus
);
    localparam int DEPTH = 2**PTR_WIDTH;
    localparam int CW = PTR_WIDTH+1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt, count_nxt;
    logic                  wr_ok, rd_ok;

    // A full FIFO still takes a write when a read frees a slot on the same edge
    always_comb begin
        rd_ok = bus.rd_en && !bus.empty;
        wr_ok = bus.wr_en && (!bus.full || rd_ok);
        wr_nxt = wr_ptr + CW'(wr_ok);
        rd_nxt = rd_ptr + CW'(rd_ok);
        count_nxt = bus.count + CW'(wr_ok) - CW'(rd_ok);
    end

    // Storage is never cleared; only accepted writes land in it
    always_ff @(posedge aclk)
        if (!areset && wr_ok) mem[wr_ptr[PTR_WIDTH-1:0]] <= bus.data_wr;

    // Pointers, status flags, read data and error pulses
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            bus.count <= '0;
            bus.empty <= 1'b1;
            bus.full  <= 1'b0;
            bus.data_rd <= '0;
            bus.oflow <= 1'b0;
            bus.uflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_nxt;
            rd_ptr    <= rd_nxt;
            bus.count <= count_nxt;
            bus.empty <= wr_nxt == rd_nxt;
            bus.full  <= (wr_nxt[PTR_WIDTH] != rd_nxt[PTR_WIDTH]) &&
                         (wr_nxt[PTR_WIDTH-1:0] == rd_nxt[PTR_WIDTH-1:0]);
            bus.data_rd <= rd_ok ? mem[rd_ptr[PTR_WIDTH-1:0]] : bus.data_rd;
            bus.oflow <= bus.wr_en && !wr_ok;
            bus.uflow <= bus.rd_en && bus.empty;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    // Threshold flags track the post-edge occupancy, same timing as count
    always_ff @(posedge aclk) begin
        if (areset) begin
            bus.almost_full  <= 1'b0;
            bus.almost_empty <= 1'b1;
        end else begin
            bus.almost_full  <= count_nxt >= CW'(AF_LEVEL);
            bus.almost_empty <= count_nxt <= CW'(AE_LEVEL);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: directed scoreboard bench for fifo_sync (PTR_WIDTH=8, DATA_WIDTH=1)
module tb_fifo_sync;
    localparam int PW = 8;
    localparam int DW = 1;
    localparam int DEPTH = 2**PW;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mcount = 0;
    bit   model[$];
    bit   exp_q[$];
    bit   last_rd = 1'b0;

    fifo_sync_if #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) bus();
    fifo_sync #(.PTR_WIDTH(PW), .DATA_WIDTH(DW)) dut(.aclk(aclk), .areset(areset), .bus(bus));

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input bit of, input bit uf);
        chk({tag, " count"}, int'(bus.count), mcount);
        chk({tag, " full"}, int'(bus.full), int'(mcount == DEPTH));
        chk({tag, " empty"}, int'(bus.empty), int'(mcount == 0));
        chk({tag, " oflow"}, int'(bus.oflow), int'(of));
        chk({tag, " uflow"}, int'(bus.uflow), int'(uf));
`ifdef FIFO_ALMOST_FLAGS_EN
        chk({tag, " almost_full"}, int'(bus.almost_full), int'(mcount >= DEPTH-4));
        chk({tag, " almost_empty"}, int'(bus.almost_empty), int'(mcount <= 4));
`endif
    endtask

    // Drive one cycle of stimulus, update the reference queue, check status after the edge
    task automatic step(input string tag, input bit wr, input bit d, input bit rd);
        bit rok, wok, of, uf;
        bus.wr_en = wr;
        bus.data_wr = d;
        bus.rd_en = rd;
        rok = rd && mcount > 0;
        wok = wr && (mcount < DEPTH || rok);
        of = wr && !wok;
        uf = rd && mcount == 0;
        if (rok) begin
            last_rd = model.pop_front();
            exp_q.push_back(last_rd);
        end
        if (wok) model.push_back(d);
        mcount = model.size();
        @(posedge aclk);
        #1;
        chk_status(tag, of, uf);
    endtask

    task automatic do_reset(input int n);
        areset = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_wr = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
        areset = 1'b0;
        model.delete();
        exp_q.delete();
        mcount = 0;
        last_rd = 1'b0;
        chk_status("reset", 1'b0, 1'b0);
        chk("reset data_rd", int'(bus.data_rd), 0);
    endtask

    // Monitor: whenever a read is taken on an edge, the next data_rd must be the queue head
    initial begin
        bit exp;
        forever begin
            @(posedge aclk);
            if (!areset && bus.rd_en && !bus.empty) begin
                #2;
                if (exp_q.size() == 0) begin
                    chk("data_rd unexpected read", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("data_rd", int'(bus.data_rd), int'(exp));
                end
            end
        end
    end

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.data_wr = 1'b0;
        do_reset(40);

        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, i[0], 1'b0);
        chk("fill full", int'(bus.full), 1);
        chk("fill count", int'(bus.count), 256);

        step("overflow", 1'b1, 1'b0, 1'b0);
        step("after overflow", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b0, 1'b1);
        step("drain idle", 1'b0, 1'b0, 1'b0);
        chk("last word is 256th written", int'(last_rd), 1);

        step("underflow", 1'b0, 1'b0, 1'b1);
        chk("underflow data_rd held", int'(bus.data_rd), int'(last_rd));
        step("underflow idle", 1'b0, 1'b0, 1'b0);
        step("empty rd+wr", 1'b1, 1'b0, 1'b1);
        chk("empty rd+wr data_rd held", int'(bus.data_rd), int'(last_rd));

        for (int i = 0; i < 9; i++) step("prefill", 1'b1, i[1], 1'b0);
        for (int i = 0; i < 300; i++) step("simul", 1'b1, i[0] ^ i[2], 1'b1);
        for (int i = 0; i < 10; i++) step("simul drain", 1'b0, 1'b0, 1'b1);
        step("simul idle", 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 100; i++) step("pre-reset", 1'b1, i[0], 1'b0);
        do_reset(1);
        step("post-reset wr", 1'b1, 1'b1, 1'b0);
        step("post-reset rd", 1'b0, 1'b0, 1'b1);
        step("post-reset idle", 1'b0, 1'b0, 1'b0);
        chk("post-reset data_rd", int'(bus.data_rd), 1);

        repeat (2) @(posedge aclk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
